camera_feature_head: RTL and testbench

- Streaming post-convolution head for the camera path.
- Accepts conv accumulator outputs one pixel per beat, all C channels per beat, over a ready/valid handshake.
- Per beat: ReLU, saturating shift-requantisation to INT8, running per-channel global max pool over H*W pixels.
- At frame end: per-channel batch-norm, serialised one channel per cycle. Emits a C*8-bit INT8 feature vector over a ready/valid output with back-pressure.
- Generalises the fixed 16x8x32 extractor back end: parametrised dims, programmable requant shift and inv_std, frame framing checks.

---
 rtl/camera_feature_head_pkg.sv | 52 +++++
 rtl/camera_feature_head_bn_lane.sv | 30 +++
 rtl/camera_feature_head.sv | 140 ++++++++++++++
 tb/tb_camera_feature_head.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/camera_feature_head_pkg.sv
// Shared types and arithmetic helpers for the camera feature head.
// Includes the requantisation and INT8 saturation functions used by the datapath.
package cam_feat_pkg;

   typedef enum logic [1:0] {
      ACCUM = 2'd0,
      NORM  = 2'd1,
      OUT   = 2'd2
   } state_e;

   localparam int INT8_MAX = 127;
   localparam int INT8_MIN = -128;

   function automatic int npix(input int h, input int w);
      return h * w;
   endfunction

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic [7:0] sat_int8(input logic signed [31:0] v);
      logic [7:0] res;
      if (v > 32'sd127) begin
         res = 8'h7F;
      end else if (v < -32'sd128) begin
         res = 8'h80;
      end else begin
         res = v[7:0];
      end
      return res;
   endfunction

   // ReLU, then right shift, then clamp to the positive INT8 range.
   function automatic logic [7:0] requant(input logic signed [31:0] acc, input logic [3:0] shift);
      logic [31:0] r;
      logic [7:0]  res;
      if (acc[31]) begin
         r = 32'd0;
      end else begin
         r = 32'(acc);
      end
      r = r >> shift;
      if (r > 32'd127) begin
         res = 8'd127;
      end else begin
         res = r[7:0];
      end
      return res;
   endfunction

endpackage

// File: rtl/camera_feature_head_bn_lane.sv
// Combinational batch-norm lane: y = sat(((x - mean) * inv_std * gamma) >>> FRAC + beta).
// A single lane is shared by all channels; the caller selects the channel.
module cam_bn_lane
   import cam_feat_pkg::*;
#(
   parameter int FRAC = 6
) (
   input  logic [7:0] x_i,
   input  logic [7:0] mean_i,
   input  logic [7:0] inv_std_i,
   input  logic [7:0] gamma_i,
   input  logic [7:0] beta_i,
   output logic [7:0] y_o
);

   logic signed [8:0]  d_s;
   logic signed [17:0] p_s;
   logic signed [25:0] s_s;
   logic signed [25:0] t_s;
   logic signed [31:0] y_s;

   // x is 0..127 and mean is signed, so the difference always fits 9 signed bits
   assign d_s = signed'({1'b0, x_i}) - 9'(signed'(mean_i));
   assign p_s = 18'(d_s) * signed'(18'({1'b0, inv_std_i}));
   assign s_s = 26'(p_s) * 26'(signed'(gamma_i));
   assign t_s = s_s >>> FRAC;
   assign y_s = 32'(t_s) + 32'(signed'(beta_i));
   assign y_o = sat_int8(y_s);

endmodule

// File: rtl/camera_feature_head.sv
// Streaming post-convolution head: ReLU + requant + global max pool per pixel,
// then per-channel batch-norm serialised one channel per cycle into an INT8 vector.
module camera_feature_head
   import cam_feat_pkg::*;
#(
   parameter int C     = 32,
   parameter int ACC_W = 16,
   parameter int H     = 16,
   parameter int W     = 8,
   parameter int FRAC  = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic [C*ACC_W-1:0] s_data,
   input  logic               s_last,
   input  logic [3:0]         quant_shift,
   input  logic [C*8-1:0]     bn_gamma,
   input  logic [C*8-1:0]     bn_beta,
   input  logic [C*8-1:0]     bn_mean,
   input  logic [C*8-1:0]     bn_inv_std,
   output logic               m_valid,
   input  logic               m_ready,
   output logic [C*8-1:0]     m_data,
   output logic               frame_err
);

   localparam int NPIX = npix(H, W);
   localparam int PCW  = cnt_w(NPIX);
   localparam int CIW  = cnt_w(C);

   state_e           state_q, state_d;
   logic [PCW-1:0]   pix_cnt_q, pix_cnt_d;
   logic [CIW-1:0]   ch_idx_q, ch_idx_d;
   logic [C*8-1:0]   max_q, max_d;
   logic [C*8-1:0]   m_data_q, m_data_d;
   logic             m_valid_q, m_valid_d;
   logic             frame_err_q, frame_err_d;
   logic [C*8-1:0]   max_upd_s;
   logic             beat_s;
   logic [7:0]       lane_y_s;

   assign s_ready   = (state_q == ACCUM);
   assign beat_s    = s_valid && (state_q == ACCUM);
   assign m_valid   = m_valid_q;
   assign m_data    = m_data_q;
   assign frame_err = frame_err_q;

   // First pixel of a frame overwrites the running max, which clears any stale frame.
   for (genvar g = 0; g < C; g++) begin : g_pool
      logic [7:0] q_s;
      assign q_s = requant(32'(signed'(s_data[g*ACC_W +: ACC_W])), quant_shift);
      assign max_upd_s[g*8 +: 8] =
         ((pix_cnt_q == {PCW{1'b0}}) || (q_s > max_q[g*8 +: 8])) ? q_s : max_q[g*8 +: 8];
   end

   cam_bn_lane #(.FRAC(FRAC)) u_bn_lane (
      .x_i       (max_q[ch_idx_q*8 +: 8]),
      .mean_i    (bn_mean[ch_idx_q*8 +: 8]),
      .inv_std_i (bn_inv_std[ch_idx_q*8 +: 8]),
      .gamma_i   (bn_gamma[ch_idx_q*8 +: 8]),
      .beta_i    (bn_beta[ch_idx_q*8 +: 8]),
      .y_o       (lane_y_s)
   );

   // Next-state logic for framing, pooling, normalisation and output handshake.
   always_comb begin
      state_d     = state_q;
      pix_cnt_d   = pix_cnt_q;
      ch_idx_d    = ch_idx_q;
      max_d       = max_q;
      m_data_d    = m_data_q;
      m_valid_d   = m_valid_q;
      frame_err_d = 1'b0;
      case (state_q)
         ACCUM: begin
            if (beat_s) begin
               max_d = max_upd_s;
               if (pix_cnt_q == PCW'(NPIX - 1)) begin
                  pix_cnt_d   = {PCW{1'b0}};
                  ch_idx_d    = {CIW{1'b0}};
                  state_d     = NORM;
                  frame_err_d = !s_last;
               end else if (s_last) begin
                  pix_cnt_d   = {PCW{1'b0}};
                  frame_err_d = 1'b1;
               end else begin
                  pix_cnt_d = pix_cnt_q + PCW'(1);
               end
            end else begin
               pix_cnt_d = pix_cnt_q;
            end
         end
         NORM: begin
            m_data_d[ch_idx_q*8 +: 8] = lane_y_s;
            if (ch_idx_q == CIW'(C - 1)) begin
               ch_idx_d  = {CIW{1'b0}};
               m_valid_d = 1'b1;
               state_d   = OUT;
            end else begin
               ch_idx_d = ch_idx_q + CIW'(1);
            end
         end
         OUT: begin
            if (m_ready) begin
               m_valid_d = 1'b0;
               state_d   = ACCUM;
            end else begin
               m_valid_d = 1'b1;
            end
         end
         default: begin
            state_d = ACCUM;
         end
      endcase
   end

   // State and datapath registers; reset discards any partial frame or pending output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ACCUM;
         pix_cnt_q   <= {PCW{1'b0}};
         ch_idx_q    <= {CIW{1'b0}};
         max_q       <= {(C*8){1'b0}};
         m_data_q    <= {(C*8){1'b0}};
         m_valid_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pix_cnt_q   <= pix_cnt_d;
         ch_idx_q    <= ch_idx_d;
         max_q       <= max_d;
         m_data_q    <= m_data_d;
         m_valid_q   <= m_valid_d;
         frame_err_q <= frame_err_d;
      end
   end

endmodule

// File: tb/tb_camera_feature_head.sv
// Directed self-checking bench for camera_feature_head with a 4-channel, 2x2 frame.
module tb_camera_feature_head;

   localparam int C     = 4;
   localparam int ACC_W = 16;
   localparam int H     = 2;
   localparam int W     = 2;
   localparam int FRAC  = 6;
   localparam int NPIX  = H * W;

   logic               clk;
   logic               rst_n;
   logic               s_valid;
   logic               s_ready;
   logic [C*ACC_W-1:0] s_data;
   logic               s_last;
   logic [3:0]         quant_shift;
   logic [C*8-1:0]     bn_gamma;
   logic [C*8-1:0]     bn_beta;
   logic [C*8-1:0]     bn_mean;
   logic [C*8-1:0]     bn_inv_std;
   logic               m_valid;
   logic               m_ready;
   logic [C*8-1:0]     m_data;
   logic               frame_err;

   int checks_r = 0;
   int errors_r = 0;

   camera_feature_head #(
      .C(C), .ACC_W(ACC_W), .H(H), .W(W), .FRAC(FRAC)
   ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_data      (s_data),
      .s_last      (s_last),
      .quant_shift (quant_shift),
      .bn_gamma    (bn_gamma),
      .bn_beta     (bn_beta),
      .bn_mean     (bn_mean),
      .bn_inv_std  (bn_inv_std),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_data      (m_data),
      .frame_err   (frame_err)
   );

   // Free-running clock, 10 ns period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_r++;
      if (got !== exp) begin
         errors_r++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [C*ACC_W-1:0] pix(input int a, input int b, input int c, input int d);
      return {16'(d), 16'(c), 16'(b), 16'(a)};
   endfunction

   function automatic logic [C*8-1:0] bn8(input int a, input int b, input int c, input int d);
      return {8'(d), 8'(c), 8'(b), 8'(a)};
   endfunction

   task automatic send_beat(input logic [C*ACC_W-1:0] d, input logic last);
      int n = 0;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = last;
      while (!s_ready && n < 100) begin
         step();
         n++;
      end
      if (n >= 100) chk("beat_timeout", 32'(s_ready), 32'd1);
      step();
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic run_frame(input logic [4*C*ACC_W-1:0] px, input logic [3:0] last_mask);
      for (int i = 0; i < NPIX; i++) begin
         send_beat(px[i*C*ACC_W +: C*ACC_W], last_mask[i]);
      end
   endtask

   // m_valid must rise exactly C edges after the final beat is accepted.
   task automatic expect_out(input string tag, input logic [C*8-1:0] exp);
      for (int i = 1; i <= C; i++) begin
         step();
         if (i == C - 1) chk({tag, "_early"}, 32'(m_valid), 32'd0);
      end
      chk({tag, "_mvalid"}, 32'(m_valid), 32'd1);
      chk({tag, "_data"}, m_data, exp);
   endtask

   task automatic drain(input string tag);
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
      chk({tag, "_mvalid_lo"}, 32'(m_valid), 32'd0);
      chk({tag, "_sready"}, 32'(s_ready), 32'd1);
   endtask

   task automatic bn_unity();
      bn_gamma   = bn8(1, 1, 1, 1);
      bn_inv_std = bn8(64, 64, 64, 64);
      bn_mean    = bn8(0, 0, 0, 0);
      bn_beta    = bn8(0, 0, 0, 0);
   endtask

   // Directed stimulus sequence.
   initial begin
      int bad;
      int mv_seen;
      rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
      quant_shift = 4'd0;
      bn_unity();
      step(); step();
      rst_n = 1'b1;
      step();
      chk("rst_mvalid", 32'(m_valid), 32'd0);
      chk("rst_mdata", m_data, 32'd0);
      chk("rst_ferr", 32'(frame_err), 32'd0);
      chk("rst_sready", 32'(s_ready), 32'd1);

      // Frame A: basic max pool with unity BN, then a 20-cycle stall.
      run_frame({pix(20, -4, 3, 6), pix(100, -3, 2, 9), pix(-3, -2, 1, 8), pix(5, -1, 300, 7)}, 4'b1000);
      chk("a_ferr", 32'(frame_err), 32'd0);
      expect_out("a", 32'h097F0064);
      s_valid = 1'b1; s_data = pix(32767, 32767, 32767, 32767); s_last = 1'b1;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (m_data !== 32'h097F0064 || s_ready !== 1'b0 || m_valid !== 1'b1) bad++;
      end
      chk("hold_stable", 32'(bad), 32'd0);
      s_valid = 1'b0; s_last = 1'b0;
      drain("a");

      // Frame B: requant saturation and BN saturation / negative / floor paths.
      quant_shift = 4'd2;
      bn_gamma   = bn8(127, -128, 1, 1);
      bn_inv_std = bn8(64, 64, 64, 1);
      bn_mean    = bn8(-1, 0, 10, 1);
      bn_beta    = bn8(100, -128, 0, 0);
      run_frame({pix(0, 0, -8, -32768), pix(0, 0, -7, -32768), pix(0, 0, -6, -32768),
                 pix(1000, 508, -5, -32768)}, 4'b1000);
      expect_out("b", 32'hFFF6807F);
      drain("b");

      // Frame C: large shift zeroes everything; missing s_last flags but still outputs.
      quant_shift = 4'd15;
      bn_unity();
      bn_beta = bn8(3, -4, 0, 5);
      run_frame({4{pix(32767, 32767, 32767, 32767)}}, 4'b0000);
      chk("c_ferr", 32'(frame_err), 32'd1);
      expect_out("c", 32'h0500FC03);
      chk("c_ferr_done", 32'(frame_err), 32'd0);
      drain("c");

      // Frame D: early s_last discards the frame.
      quant_shift = 4'd0;
      bn_unity();
      send_beat(pix(100, 100, 100, 100), 1'b0);
      send_beat(pix(100, 100, 100, 100), 1'b1);
      chk("d_ferr", 32'(frame_err), 32'd1);
      mv_seen = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (m_valid) mv_seen++;
      end
      chk("d_no_out", 32'(mv_seen), 32'd0);
      chk("d_sready", 32'(s_ready), 32'd1);

      // Frame E: no residue from the discarded frame.
      run_frame({4{pix(1, 2, 3, 4)}}, 4'b1000);
      expect_out("e", 32'h04030201);
      drain("e");

      // Frame F aborted by reset during NORM, then frame G.
      run_frame({4{pix(50, 50, 50, 50)}}, 4'b1000);
      step();
      rst_n = 1'b0;
      #2;
      chk("rstn_mvalid", 32'(m_valid), 32'd0);
      chk("rstn_mdata", m_data, 32'd0);
      chk("rstn_sready", 32'(s_ready), 32'd1);
      step();
      rst_n = 1'b1;
      step();
      run_frame({pix(5, 0, 7, -128), pix(-1, 0, 7, 128), pix(60, 0, 7, 127), pix(10, 0, 7, 126)}, 4'b1000);
      expect_out("g", 32'h7F07003C);
      drain("g");

      $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
